data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 256, meaning the number of 32-bit RAM words (power of two, 16..4096).
REQ-002 The block SHALL expose parameter IO_BASE, default 32'hFFFF_FFF0, meaning the word address of the first memory-mapped register.
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 ADDR  input  32  word address from the CPU data bus.
REQ-006 Data_BUS_WRITE  input  32  write data from the CPU.
REQ-007 CS  input  1  chip select; the bus access is valid only when 1.
REQ-008 WE  input  1  write enable; 1=write, 0=read; ignored when CS=0.
REQ-009 Data_BUS_READ  output  32  registered read data to the CPU.
REQ-010 IO_OUT  output  32  general-purpose output register.
REQ-011 ERR  output  1  sticky bus-error flag.

Function
REQ-012 The address map SHALL be: ADDR<DEPTH -> RAM word ADDR[log2(DEPTH)-1:0]; IO_BASE -> IO_OUT (R/W); IO_BASE+4 -> CYCLES (RO); IO_BASE+8 -> STATUS (R/W); every other address -> unmapped.
REQ-013 A write SHALL occur at the rising edge where CS=1 and WE=1, updating the selected RAM word or register, with the new value visible to a read beginning the next cycle.
REQ-014 A read SHALL be captured at the rising edge where CS=1 and WE=0, with Data_BUS_READ holding the addressed value after that edge (1-cycle latency).
REQ-015 Data_BUS_READ SHALL hold its last value on any cycle with CS=0 or with WE=1.
REQ-016 CYCLES SHALL be a 32-bit free-running counter that increments every cycle from 0 after reset and wraps from 32'hFFFF_FFFF to 0.
REQ-017 A read of CYCLES SHALL return the counter value sampled at the same edge as the read.
REQ-018 A write to CYCLES SHALL be ignored and SHALL set ERR.
REQ-019 A read of STATUS SHALL return {31'b0, ERR}.
REQ-020 A write to STATUS with Data_BUS_WRITE[0]=1 SHALL clear ERR; a write with bit0=0 SHALL have no effect.
REQ-021 An unmapped read SHALL return 32'h0000_0000 and set ERR.
REQ-022 An unmapped write SHALL discard its data and set ERR.
REQ-023 ERR SHALL be sticky and remain 1 until it is cleared via STATUS or by Reset.
REQ-024 If an error event and a STATUS clear occur in the same cycle, the STATUS clear SHALL win because the two are mutually exclusive per access, and ERR SHALL then be 0.
REQ-025 A read of IO_OUT SHALL return the current register value.
REQ-026 Back-to-back accesses on consecutive cycles SHALL each complete with no wait state and no lost access.
REQ-027 A read of an address written in the immediately preceding cycle SHALL return the new data.
REQ-028 The RAM SHALL be inferable as single-port synchronous block RAM.

Reset
REQ-029 While Reset=1, Data_BUS_READ, IO_OUT, CYCLES and ERR SHALL be 0 immediately, without waiting for a clock edge.
REQ-030 Reset SHALL NOT initialise RAM contents, and a RAM read before any write to that word returns an unspecified value.
REQ-031 Reset asserted mid-access SHALL abort the access, and no write SHALL take effect at any edge where Reset=1.
REQ-032 After Reset deasserts, CYCLES SHALL read 0 at the first rising edge and then increment by 1 per edge.

Verification
REQ-033 RAM write/read: write 32'hDEAD_BEEF to ADDR=5, then read ADDR=5 on the next cycle -> Data_BUS_READ=32'hDEAD_BEEF one cycle after the read edge, and ERR=0.
REQ-034 Hold behaviour: after reading 32'h1234_5678, drive CS=0 for 3 cycles and then perform a write cycle -> Data_BUS_READ stays 32'h1234_5678 throughout.
REQ-035 IO and wrap: write 32'h0000_00A5 to IO_BASE -> IO_OUT=32'h0000_00A5 after that edge, and a read of IO_BASE returns 32'h0000_00A5; force CYCLES to 32'hFFFF_FFFE via the bench -> it reads 32'hFFFF_FFFF, then 0.
REQ-036 Error path: read ADDR=32'h0001_0000 -> Data_BUS_READ=0 and ERR=1; ERR persists 10 cycles; a STATUS write of 0 leaves ERR=1; a STATUS write of 1 gives ERR=0 after that edge; a write to CYCLES then sets ERR=1.
REQ-037 Back-to-back: write ADDR 0..7 with values 8'h10+i on consecutive cycles, then read them on consecutive cycles -> each value is returned with exactly 1-cycle latency and none is missing.
REQ-038 Async reset: assert Reset between clock edges during a write to IO_BASE -> IO_OUT=0, ERR=0, Data_BUS_READ=0 immediately, and the write is not applied.

Source files
------------

// File: rtl/data_memory.sv
// Purpose : CPU data memory -- single-port RAM plus memory-mapped IO_OUT, CYCLES and STATUS registers.
// Latency : writes land at the CS&WE edge; reads return on Data_BUS_READ one cycle after the CS&~WE edge.
// Backpressure: none; every access completes in one cycle, back-to-back, with no wait states.
//
// Ports:
//   CLK            system clock, all state changes on the rising edge
//   Reset          asynchronous active-high reset (clears read data, IO_OUT, CYCLES, ERR; RAM untouched)
//   ADDR           word address from the CPU
//   Data_BUS_WRITE write data from the CPU
//   CS / WE        chip select / write enable (WE ignored when CS=0)
//   Data_BUS_READ  registered read data, holds between reads
//   IO_OUT         general-purpose output register (IO_BASE)
//   ERR            sticky bus-error flag, cleared by writing 1 to STATUS bit 0
module data_memory #(
    parameter int          DEPTH   = 256,
    parameter logic [31:0] IO_BASE = 32'hFFFF_FFF0
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    input  logic        CS,
    input  logic        WE,
    output logic [31:0] Data_BUS_READ,
    output logic [31:0] IO_OUT,
    output logic        ERR
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [31:0] CYC_ADDR  = IO_BASE + 32'd4;
    localparam logic [31:0] STAT_ADDR = IO_BASE + 32'd8;

    // ---------------- address decode ----------------
    logic          ram_hit, io_hit, cyc_hit, stat_hit, unmapped;
    logic          rd_acc, wr_acc;
    logic [AW-1:0] ram_idx;

    assign ram_hit  = (ADDR < DEPTH_W);
    assign io_hit   = !ram_hit && (ADDR == IO_BASE);
    assign cyc_hit  = !ram_hit && (ADDR == CYC_ADDR);
    assign stat_hit = !ram_hit && (ADDR == STAT_ADDR);
    assign unmapped = !(ram_hit || io_hit || cyc_hit || stat_hit);
    assign ram_idx  = ADDR[AW-1:0];

    assign rd_acc = CS && !WE;
    assign wr_acc = CS && WE;

    // ---------------- RAM ----------------
    // Plain synchronous single-port array with a read-enabled output
    // register and no reset, so it maps onto block RAM. Reset is folded
    // into the enables so no access can take effect at an edge where
    // Reset is high.
    logic [31:0] mem [DEPTH];
    logic [31:0] ram_q;
    logic        ram_we, ram_re;

    assign ram_we = wr_acc && ram_hit && !Reset;
    assign ram_re = rd_acc && ram_hit && !Reset;

    always_ff @(posedge CLK) begin
        if (ram_we) mem[ram_idx] <= Data_BUS_WRITE;
        if (ram_re) ram_q <= mem[ram_idx];
    end

    // ---------------- registers ----------------
    logic [31:0] cycles;
    logic [31:0] reg_rdata;
    logic [31:0] rd_reg;
    logic        rd_from_ram;
    logic        err_nxt;

    always_comb begin
        reg_rdata = 32'h0;
        if (io_hit)        reg_rdata = IO_OUT;
        else if (cyc_hit)  reg_rdata = cycles;
        else if (stat_hit) reg_rdata = {31'b0, ERR};
    end

    // A STATUS clear and an error event cannot come from the same access,
    // but the clear is checked first so it wins regardless.
    always_comb begin
        err_nxt = ERR;
        if (CS) begin
            if (WE && stat_hit && Data_BUS_WRITE[0])
                err_nxt = 1'b0;
            else if (unmapped || (WE && cyc_hit))
                err_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cycles      <= 32'h0;
            IO_OUT      <= 32'h0;
            ERR         <= 1'b0;
            rd_reg      <= 32'h0;
            rd_from_ram <= 1'b0;
        end else begin
            cycles <= cycles + 32'd1;
            ERR    <= err_nxt;
            if (wr_acc && io_hit) IO_OUT <= Data_BUS_WRITE;
            // Source select and register snapshot only move on a read,
            // which is what makes Data_BUS_READ hold between reads.
            if (rd_acc) begin
                rd_from_ram <= ram_hit;
                rd_reg      <= reg_rdata;
            end
        end
    end

    // rd_from_ram resets to 0 and rd_reg to 0, so the bus reads 0 during
    // reset without waiting for a clock edge.
    assign Data_BUS_READ = rd_from_ram ? ram_q : rd_reg;

endmodule

// File: tb/tb_data_memory.sv
// Purpose : directed self-checking bench for data_memory.
// Latency : stimulus driven on the falling edge, outputs sampled on the following falling edge.
// Backpressure: not applicable.
module tb_data_memory;

    localparam logic [31:0] IO_BASE   = 32'hFFFF_FFF0;
    localparam logic [31:0] CYC_ADDR  = 32'hFFFF_FFF4;
    localparam logic [31:0] STAT_ADDR = 32'hFFFF_FFF8;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic        CS;
    logic        WE;
    logic [31:0] Data_BUS_READ;
    logic [31:0] IO_OUT;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    data_memory #(.DEPTH(256), .IO_BASE(IO_BASE)) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .CS             (CS),
        .WE             (WE),
        .Data_BUS_READ  (Data_BUS_READ),
        .IO_OUT         (IO_OUT),
        .ERR            (ERR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic cs, input logic we, input logic [31:0] a, input logic [31:0] d);
        CS = cs;
        WE = we;
        ADDR = a;
        Data_BUS_WRITE = d;
    endtask

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        check("rst_rdata", Data_BUS_READ, 32'h0);
        check("rst_io", IO_OUT, 32'h0);
        check("rst_err", 32'(ERR), 32'h0);
        @(negedge CLK);
        tick;
        tick;

        // Release reset; CYCLES reads 0 at the first edge, then 1.
        Reset = 1'b0;
        drive(1'b1, 1'b0, CYC_ADDR, 32'h0);
        tick;
        check("cyc_first", Data_BUS_READ, 32'h0);
        tick;
        check("cyc_second", Data_BUS_READ, 32'h1);

        // RAM write then read on the next cycle.
        drive(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
        tick;
        drive(1'b1, 1'b0, 32'd5, 32'h0);
        tick;
        check("ram_rd5", Data_BUS_READ, 32'hDEAD_BEEF);
        check("ram_err", 32'(ERR), 32'h0);

        // Hold: CS=0 for 3 cycles then a write cycle.
        drive(1'b1, 1'b1, 32'd5, 32'h1234_5678);
        tick;
        drive(1'b1, 1'b0, 32'd5, 32'h0);
        tick;
        check("hold_rd", Data_BUS_READ, 32'h1234_5678);
        drive(1'b0, 1'b0, 32'd7, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("hold_idle", Data_BUS_READ, 32'h1234_5678);
        end
        drive(1'b1, 1'b1, 32'd6, 32'hAAAA_5555);
        tick;
        check("hold_wr", Data_BUS_READ, 32'h1234_5678);
        drive(1'b1, 1'b0, 32'd6, 32'h0);
        tick;
        check("ram_rd6", Data_BUS_READ, 32'hAAAA_5555);

        // Top RAM word is still RAM.
        drive(1'b1, 1'b1, 32'd255, 32'h0BAD_F00D);
        tick;
        drive(1'b1, 1'b0, 32'd255, 32'h0);
        tick;
        check("ram_rd255", Data_BUS_READ, 32'h0BAD_F00D);
        check("ram255_err", 32'(ERR), 32'h0);

        // IO_OUT write / readback.
        drive(1'b1, 1'b1, IO_BASE, 32'h0000_00A5);
        tick;
        check("io_out", IO_OUT, 32'h0000_00A5);
        drive(1'b1, 1'b0, IO_BASE, 32'h0);
        tick;
        check("io_rd", Data_BUS_READ, 32'h0000_00A5);

        // CYCLES wrap.
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        force dut.cycles = 32'hFFFF_FFFE;
        release dut.cycles;
        tick;
        drive(1'b1, 1'b0, CYC_ADDR, 32'h0);
        tick;
        check("cyc_max", Data_BUS_READ, 32'hFFFF_FFFF);
        tick;
        check("cyc_wrap", Data_BUS_READ, 32'h0);

        // Back-to-back writes then reads.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 32'(i), 32'h10 + 32'(i));
            tick;
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'(i), 32'h0);
            tick;
            check("b2b_rd", Data_BUS_READ, 32'h10 + 32'(i));
        end

        // Error path.
        drive(1'b1, 1'b0, 32'h0001_0000, 32'h0);
        tick;
        check("unmap_rd", Data_BUS_READ, 32'h0);
        check("unmap_err", 32'(ERR), 32'h1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) tick;
        check("err_sticky", 32'(ERR), 32'h1);
        drive(1'b1, 1'b1, STAT_ADDR, 32'h0);
        tick;
        check("stat_wr0", 32'(ERR), 32'h1);
        drive(1'b1, 1'b0, STAT_ADDR, 32'h0);
        tick;
        check("stat_rd1", Data_BUS_READ, 32'h1);
        drive(1'b1, 1'b1, STAT_ADDR, 32'h1);
        tick;
        check("stat_clr", 32'(ERR), 32'h0);
        drive(1'b1, 1'b0, STAT_ADDR, 32'h0);
        tick;
        check("stat_rd0", Data_BUS_READ, 32'h0);
        drive(1'b1, 1'b1, CYC_ADDR, 32'h1234);
        tick;
        check("cyc_wr_err", 32'(ERR), 32'h1);

        // Unmapped write at DEPTH must not alias onto word 0.
        drive(1'b1, 1'b1, STAT_ADDR, 32'h1);
        tick;
        drive(1'b1, 1'b1, 32'd256, 32'hFFFF_0000);
        tick;
        check("unmap_wr_err", 32'(ERR), 32'h1);
        drive(1'b1, 1'b0, 32'd0, 32'h0);
        tick;
        check("unmap_wr_ram0", Data_BUS_READ, 32'h10);
        drive(1'b1, 1'b0, IO_BASE + 32'd12, 32'h0);
        tick;
        check("unmap_rd_c", Data_BUS_READ, 32'h0);

        // Async reset in the middle of a write to IO_BASE.
        drive(1'b1, 1'b0, 32'd3, 32'h0);
        tick;
        check("pre_rst_rd", Data_BUS_READ, 32'h13);
        drive(1'b1, 1'b1, IO_BASE, 32'h0000_0077);
        #2;
        Reset = 1'b1;
        #1;
        check("arst_io", IO_OUT, 32'h0);
        check("arst_err", 32'(ERR), 32'h0);
        check("arst_rd", Data_BUS_READ, 32'h0);
        tick;
        check("arst_io_edge", IO_OUT, 32'h0);
        drive(1'b1, 1'b1, 32'd3, 32'h0000_0BAD);
        tick;
        Reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        check("post_rst_io", IO_OUT, 32'h0);
        drive(1'b1, 1'b0, 32'd3, 32'h0);
        tick;
        check("rst_no_ramwr", Data_BUS_READ, 32'h13);
        check("post_rst_err", 32'(ERR), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
